// File: rtl/key_event.sv
// ---------------------------------------------------------------------------
// key_event
//
// Turns the clean, clock-synchronous level of one debounced key into
// one-cycle key events: press, release, single click, double click,
// long press and (optionally) auto-repeat while a long press is held.
// One instance per key; consumers never have to time key levels themselves.
//
// Optional feature macro: KEY_EVENT_REPEAT_EN
//   defined   -> o_rep pulses every REP_CMAX cycles while a long press is held
//   undefined -> o_rep is tied low and no repeat logic is built
//
// Parameters:
//   LONG_CMAX  hold length in clk cycles before o_long fires (>= 2)
//   DBL_CMAX   window after a short-press release for a double click (>= 2)
//   REP_CMAX   auto-repeat interval after o_long (>= 2, repeat build only)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   d_sig      debounced key level, synchronous to clk, 1 = pressed
//   o_held     registered copy of d_sig
//   o_press    one-cycle pulse on every press
//   o_release  one-cycle pulse on every release
//   o_click    one-cycle pulse when a single short click completes
//   o_dclick   one-cycle pulse when a double click is detected
//   o_long     one-cycle pulse when the hold reaches LONG_CMAX cycles
//   o_rep      one-cycle auto-repeat pulse (0 unless repeat is built in)
// ---------------------------------------------------------------------------
module key_event #(
   parameter int LONG_CMAX = 1000000,
   parameter int DBL_CMAX  = 250000,
   parameter int REP_CMAX  = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_sig,
   output logic o_held,
   output logic o_press,
   output logic o_release,
   output logic o_click,
   output logic o_dclick,
   output logic o_long,
   output logic o_rep
);

   localparam int MAX_LD = (LONG_CMAX > DBL_CMAX) ? LONG_CMAX : DBL_CMAX;
   localparam int MAX_C  = (MAX_LD > REP_CMAX) ? MAX_LD : REP_CMAX;
   localparam int CW     = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CMAX - 1);
   localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CMAX - 1);
`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST  = CW'(REP_CMAX - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      HOLD1,
      WAITDBL,
      HOLD2,
      LONG
   } state_t;

   state_t        state;
   logic          d_q;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          rise;
   logic          fall;

   assign rise   = d_sig & ~d_q;
   assign fall   = ~d_sig & d_q;
   assign o_held = d_q;

   // Saturating increment so a counter left running can never wrap back
   // into a range that would re-trigger a timeout.
   always_comb begin
      cnt_inc = cnt;
      if (cnt != '1) begin
         cnt_inc = cnt + 1'b1;
      end
   end

   // Single state machine with one shared counter. The counter is cleared on
   // every state change, so each state measures time since it was entered.
   // All event outputs are registered pulses that default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         d_q       <= 1'b0;
         cnt       <= '0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_click   <= 1'b0;
         o_dclick  <= 1'b0;
         o_long    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
         o_rep     <= 1'b0;
`endif
      end else begin
         d_q       <= d_sig;
         o_press   <= rise;
         o_release <= fall;
         o_click   <= 1'b0;
         o_dclick  <= 1'b0;
         o_long    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
         o_rep     <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= HOLD1;
                  cnt   <= '0;
               end
            end
            HOLD1: begin
               if (fall) begin
                  state <= WAITDBL;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  o_long <= 1'b1;
                  state  <= LONG;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            // A rise on the very cycle the window expires still counts as
            // the second press, so the rise test comes first.
            WAITDBL: begin
               if (rise) begin
                  o_dclick <= 1'b1;
                  state    <= HOLD2;
                  cnt      <= '0;
               end else if (cnt == DBL_LAST) begin
                  o_click <= 1'b1;
                  state   <= IDLE;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            // Releasing the second press of a double click opens no new
            // window; the double click has already been reported.
            HOLD2: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  o_long <= 1'b1;
                  state  <= LONG;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            LONG: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
`ifdef KEY_EVENT_REPEAT_EN
               end else if (cnt == REP_LAST) begin
                  o_rep <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
`endif
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifndef KEY_EVENT_REPEAT_EN
   assign o_rep = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// ---------------------------------------------------------------------------
// tb_key_event
//
// Directed bench for key_event with LONG_CMAX=100, DBL_CMAX=50, REP_CMAX=20.
// A cycle-accurate vector table covers short glitch/double-click sequences;
// hand-written sequences cover reset, single click, double click, long press,
// the double-click window boundary and reset in the middle of a window.
// A monitor logs the cycle number of every output pulse so the sequences can
// check pulse spacing against hand-computed distances.
// ---------------------------------------------------------------------------
module tb_key_event;

   localparam int LONG_C = 100;
   localparam int DBL_C  = 50;
   localparam int REP_C  = 20;

   logic clk;
   logic rst_n;
   logic d_sig;
   logic o_held;
   logic o_press;
   logic o_release;
   logic o_click;
   logic o_dclick;
   logic o_long;
   logic o_rep;
   logic [6:0] outs;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int press_q[$];
   int release_q[$];
   int click_q[$];
   int dclick_q[$];
   int long_q[$];
   int rep_q[$];

   typedef struct {
      logic       d;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[10];

   key_event #(
      .LONG_CMAX(LONG_C),
      .DBL_CMAX (DBL_C),
      .REP_CMAX (REP_C)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d_sig    (d_sig),
      .o_held   (o_held),
      .o_press  (o_press),
      .o_release(o_release),
      .o_click  (o_click),
      .o_dclick (o_dclick),
      .o_long   (o_long),
      .o_rep    (o_rep)
   );

   assign outs = {o_held, o_press, o_release, o_click, o_dclick, o_long, o_rep};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse logger: each pulse is stamped with the number of rising edges
   // seen so far, i.e. the edge that produced it.
   always @(negedge clk) begin
      if (o_press)   press_q.push_back(cyc);
      if (o_release) release_q.push_back(cyc);
      if (o_click)   click_q.push_back(cyc);
      if (o_dclick)  dclick_q.push_back(cyc);
      if (o_long)    long_q.push_back(cyc);
      if (o_rep)     rep_q.push_back(cyc);
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -100000;
   endfunction

   task automatic clearLog();
      press_q.delete();
      release_q.delete();
      click_q.delete();
      dclick_q.delete();
      long_q.delete();
      rep_q.delete();
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one clock cycle of d_sig and leave the caller just after the
   // rising edge that sampled it, with outputs settled.
   task automatic applyStimulus(input logic d);
      @(negedge clk);
      d_sig = d;
      @(posedge clk);
      #1;
   endtask

   task automatic applyRun(input logic d, input int n);
      for (int i = 0; i < n; i++) applyStimulus(d);
   endtask

   initial begin
      vecs[0] = '{1'b0, 7'b0000000};
      vecs[1] = '{1'b1, 7'b1100000};
      vecs[2] = '{1'b0, 7'b0010000};
      vecs[3] = '{1'b0, 7'b0000000};
      vecs[4] = '{1'b1, 7'b1100100};
      vecs[5] = '{1'b1, 7'b1000000};
      vecs[6] = '{1'b0, 7'b0010000};
      vecs[7] = '{1'b0, 7'b0000000};
      vecs[8] = '{1'b1, 7'b1100000};
      vecs[9] = '{1'b0, 7'b0010000};

      // Reset held with the key pressed
      rst_n = 1'b0;
      d_sig = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", int'(outs), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_press", int'(outs), int'(7'b1100000));
      applyStimulus(1'b1);
      checkOutput("post_reset_press_clears", int'(outs), int'(7'b1000000));
      applyRun(1'b0, 60);

      // Cycle-accurate table: glitch, double click via glitch, short press
      $display("[TB] vector table");
      clearLog();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].d);
         checkOutput($sformatf("vec%0d", i), int'(outs), int'(vecs[i].exp));
      end
      applyRun(1'b0, 60);
      checkOutput("vec_click_count", click_q.size(), 1);
      checkOutput("vec_click_delay", qat(click_q, 0) - qat(release_q, 2), DBL_C);

      // Single click
      $display("[TB] single click");
      clearLog();
      applyRun(1'b1, 30);
      applyRun(1'b0, 60);
      checkOutput("sc_press_count", press_q.size(), 1);
      checkOutput("sc_release_delay", qat(release_q, 0) - qat(press_q, 0), 30);
      checkOutput("sc_click_count", click_q.size(), 1);
      checkOutput("sc_click_delay", qat(click_q, 0) - qat(release_q, 0), DBL_C);
      checkOutput("sc_no_dclick", dclick_q.size(), 0);
      checkOutput("sc_no_long", long_q.size(), 0);

      // Double click
      $display("[TB] double click");
      clearLog();
      applyRun(1'b1, 10);
      applyRun(1'b0, 20);
      applyRun(1'b1, 10);
      applyRun(1'b0, 60);
      checkOutput("dc_press_count", press_q.size(), 2);
      checkOutput("dc_second_press_gap", qat(press_q, 1) - qat(release_q, 0), 20);
      checkOutput("dc_dclick_count", dclick_q.size(), 1);
      checkOutput("dc_dclick_with_press", qat(dclick_q, 0), qat(press_q, 1));
      checkOutput("dc_no_click", click_q.size(), 0);
      checkOutput("dc_idle_outputs", int'(outs), 0);

      // Long press
      $display("[TB] long press");
      clearLog();
      applyRun(1'b1, 250);
      applyRun(1'b0, 30);
      checkOutput("lp_long_count", long_q.size(), 1);
      checkOutput("lp_long_delay", qat(long_q, 0) - qat(press_q, 0), LONG_C);
      checkOutput("lp_release_delay", qat(release_q, 0) - qat(press_q, 0), 250);
      checkOutput("lp_no_click", click_q.size(), 0);
`ifdef KEY_EVENT_REPEAT_EN
      checkOutput("lp_rep_count", rep_q.size(), 7);
      checkOutput("lp_rep_first", qat(rep_q, 0) - qat(long_q, 0), REP_C);
      checkOutput("lp_rep_last", qat(rep_q, 6) - qat(long_q, 0), 7 * REP_C);
`else
      checkOutput("lp_rep_count", rep_q.size(), 0);
`endif

      // Second rise exactly on the window-expiry edge
      $display("[TB] window boundary");
      clearLog();
      applyRun(1'b1, 5);
      applyRun(1'b0, DBL_C);
      applyRun(1'b1, 5);
      applyRun(1'b0, 60);
      checkOutput("wb0_gap", qat(press_q, 1) - qat(release_q, 0), DBL_C);
      checkOutput("wb0_dclick_count", dclick_q.size(), 1);
      checkOutput("wb0_dclick_with_press", qat(dclick_q, 0), qat(press_q, 1));
      checkOutput("wb0_no_click", click_q.size(), 0);

      // Second rise one cycle after expiry: click, then a fresh first press
      clearLog();
      applyRun(1'b1, 5);
      applyRun(1'b0, DBL_C + 1);
      applyRun(1'b1, 5);
      applyRun(1'b0, 60);
      checkOutput("wb1_no_dclick", dclick_q.size(), 0);
      checkOutput("wb1_click_count", click_q.size(), 2);
      checkOutput("wb1_click_delay", qat(click_q, 0) - qat(release_q, 0), DBL_C);
      checkOutput("wb1_press_after_click", qat(press_q, 1) - qat(click_q, 0), 1);
      checkOutput("wb1_second_click_delay", qat(click_q, 1) - qat(release_q, 1), DBL_C);

      // Reset in the middle of the double-click window
      $display("[TB] reset mid-window");
      clearLog();
      applyRun(1'b1, 5);
      applyRun(1'b0, 26);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rw_reset_outputs", int'(outs), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyRun(1'b0, 60);
      checkOutput("rw_no_click", click_q.size(), 0);
      checkOutput("rw_idle_outputs", int'(outs), 0);
      applyStimulus(1'b1);
      checkOutput("rw_fresh_press", int'(outs), int'(7'b1100000));
      applyStimulus(1'b0);
      checkOutput("rw_fresh_release", int'(outs), int'(7'b0010000));
      applyRun(1'b0, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
